// File: rtl/riscv_ifetch.sv
// Instruction fetch stage: owns the PC, issues word fetches, tags in-order
// responses with their PC and buffers them for decode. Redirects flush the
// buffer and drop every stale response that is still in flight.
module riscv_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstb,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {StReset, StRun} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  // Fetches accepted by memory whose response has not yet arrived.
  logic [CntW-1:0] out_q, out_d;
  // Responses still owed to fetches issued before the latest redirect.
  logic [CntW-1:0] drop_q, drop_d;

  // Tag queue: PC of each live (non-dropped) outstanding fetch, in order.
  logic [31:0]     tag_q [DEPTH];
  logic [31:0]     tag_d [DEPTH];
  logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  // Output FIFO of {pc, instr}.
  logic [31:0]     fpc_q    [DEPTH];
  logic [31:0]     fpc_d    [DEPTH];
  logic [31:0]     finstr_q [DEPTH];
  logic [31:0]     finstr_d [DEPTH];
  logic [PtrW-1:0] fwr_q, fwr_d, frd_q, frd_d;
  logic [CntW-1:0] fcnt_q, fcnt_d;

  logic            req_fire, rsp_keep, rsp_drop, out_pop;
  logic [CntW:0]   credit_used;

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  endfunction

  // Handshakes and outputs; a redirect blocks new requests and freezes the FIFO.
  always_comb begin
    credit_used    = {1'b0, out_q} + {1'b0, fcnt_q};
    imem_req_valid = (state_q == StRun) && (credit_used < CreditMax) && !redirect_valid;
    imem_req_addr  = pc_q;
    if_valid       = (fcnt_q != '0);
    if_pc          = if_valid ? fpc_q[frd_q] : '0;
    if_instr       = if_valid ? finstr_q[frd_q] : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    rsp_drop       = imem_rsp_valid && (drop_q != '0) && !redirect_valid;
    out_pop        = if_valid && if_ready && !redirect_valid;
  end

  // FSM next state: leave StReset on the first clock after reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset: state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StReset;
    endcase
  end

  // Datapath next state: PC, credit counters, tag queue and output FIFO.
  always_comb begin
    pc_d     = pc_q;
    drop_d   = drop_q;
    tag_d    = tag_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    fpc_d    = fpc_q;
    finstr_d = finstr_q;
    fwr_d    = fwr_q;
    frd_d    = frd_q;
    fcnt_d   = fcnt_q;

    // Outstanding tracks dropped fetches too, so it always counts every reply owed.
    out_d = out_q + (req_fire ? CntOne : '0) - (imem_rsp_valid ? CntOne : '0);

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      // Everything still owed is stale, including a response arriving right now.
      drop_d   = out_q - (imem_rsp_valid ? CntOne : '0);
      tag_wr_d = '0;
      tag_rd_d = '0;
      fwr_d    = '0;
      frd_d    = '0;
      fcnt_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d            = pc_q + 32'd4;
        tag_d[tag_wr_q] = pc_q;
        tag_wr_d        = ptr_inc(tag_wr_q);
      end
      if (rsp_drop) begin
        drop_d = drop_q - CntOne;
      end
      if (rsp_keep) begin
        fpc_d[fwr_q]    = tag_q[tag_rd_q];
        finstr_d[fwr_q] = imem_rsp_data;
        fwr_d           = ptr_inc(fwr_q);
        tag_rd_d        = ptr_inc(tag_rd_q);
      end
      if (out_pop) begin
        frd_d = ptr_inc(frd_q);
      end
      fcnt_d = fcnt_q + (rsp_keep ? CntOne : '0) - (out_pop ? CntOne : '0);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= StReset;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      fwr_q    <= '0;
      frd_q    <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        fpc_q[i]    <= '0;
        finstr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      fwr_q    <= fwr_d;
      frd_q    <= frd_d;
      fcnt_q   <= fcnt_d;
      tag_q    <= tag_d;
      fpc_q    <= fpc_d;
      finstr_q <= finstr_d;
    end
  end

  // A response is only legal for a fetch that memory actually accepted.
  rsp_has_request_a: assert property (@(posedge clk) disable iff (!rstb)
    imem_rsp_valid |-> (out_q != '0));

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: memory model with programmable latency,
// instruction word for address a is a ^ Magic.
module tb_riscv_ifetch;

  localparam logic [31:0] Magic = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;

  riscv_ifetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .imem_req_valid(req_valid),
    .imem_req_ready(req_ready),
    .imem_req_addr (req_addr),
    .imem_rsp_valid(rsp_valid),
    .imem_rsp_data (rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          acc_cnt = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: record an accept on the settled request, then drive this cycle's response.
  task automatic tick();
    @(negedge clk);
    if (rstb && req_valid && req_ready) begin
      q_addr.push_back(req_addr);
      q_due.push_back(cyc + mem_lat);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = q_addr[0] ^ Magic;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
  endtask

  // Wait (bounded) for the next output, check it, and consume it (if_ready must be 1).
  task automatic expect_out(input logic [31:0] pc);
    int n = 0;
    while (!if_valid && n < 40) begin
      tick();
      n++;
    end
    check1("out_valid", if_valid, 1'b1);
    check32("out_pc", if_pc, pc);
    check32("out_instr", if_instr, pc ^ Magic);
    tick();
  endtask

  task automatic check_reset_outputs();
    check1("rst_req_valid", req_valid, 1'b0);
    check32("rst_req_addr", req_addr, 32'h0);
    check1("rst_if_valid", if_valid, 1'b0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_instr", if_instr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb           = 1'b1;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    #1 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();

    // Release reset; the first clock only moves RESET -> RUN.
    rstb      = 1'b1;
    req_ready = 1'b1;
    if_ready  = 1'b1;
    #1;
    check1("reset_state_no_req", req_valid, 1'b0);
    tick();
    check1("first_req_valid", req_valid, 1'b1);
    check32("first_req_addr", req_addr, 32'h0);
    tick();
    check1("lat_cycle1_not_valid", if_valid, 1'b0);
    tick();
    check1("lat_cycle2_valid", if_valid, 1'b1);
    expect_out(32'h0);
    expect_out(32'h4);
    expect_out(32'h8);
    expect_out(32'hC);

    // Back-pressure: decode stalls for 10 cycles.
    if_ready = 1'b0;
    acc_cnt  = 0;
    repeat (10) tick();
    check1("stall_accepts_le_depth", acc_cnt <= 2, 1'b1);
    check1("stall_req_valid_low", req_valid, 1'b0);
    check1("stall_if_valid", if_valid, 1'b1);
    check32("stall_pc", if_pc, 32'h10);
    repeat (3) tick();
    check32("stall_pc_stable", if_pc, 32'h10);
    check32("stall_instr_stable", if_instr, 32'h10 ^ Magic);
    if_ready = 1'b1;
    expect_out(32'h10);
    expect_out(32'h14);
    expect_out(32'h18);

    // Drain, then get two fetches in flight on a 3-cycle memory and redirect.
    req_ready = 1'b0;
    repeat (6) tick();
    check1("drained", if_valid, 1'b0);
    mem_lat   = 3;
    req_ready = 1'b1;
    repeat (2) tick();
    check1("credit_stall_two_outstanding", req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check1("flush_if_valid", if_valid, 1'b0);
    check32("redirect_addr", req_addr, 32'h100);
    expect_out(32'h100);
    expect_out(32'h104);

    // Misaligned redirect target with fetches still in flight.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    check32("aligned_redirect_addr", req_addr, 32'h200);
    expect_out(32'h200);
    expect_out(32'h204);

    // PC wrap at the top of the address space.
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check32("wrap_start_addr", req_addr, 32'hFFFF_FFFC);
    expect_out(32'hFFFF_FFFC);
    expect_out(32'h0000_0000);
    expect_out(32'h0000_0004);

    // Reset mid-stream with exactly one fetch outstanding.
    mem_lat   = 3;
    req_ready = 1'b0;
    repeat (8) tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    #2;
    rstb      = 1'b0;
    rsp_valid = 1'b0;
    q_addr.delete();
    q_due.delete();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rstb      = 1'b1;
    req_ready = 1'b1;
    tick();
    check32("restart_addr", req_addr, 32'h0);
    expect_out(32'h0);
    expect_out(32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
